// File: rtl/transient_onset_detector.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// transient_onset_detector
//
// Purpose:
//   Follows an unsigned sample stream with an attack/release peak envelope.
//   It flags every transient onset, which is a sample that reaches the
//   envelope plus a threshold margin. For each onset it produces one event
//   record holding the attack peak and the rise length. The record sits in a
//   single-entry slot with a valid/ready handshake. After each event a
//   holdoff window keeps the detector from re-triggering on the same
//   transient.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_sample_in     unsigned sample, qualified by i_sample_valid
//   i_sample_valid  one-cycle strobe per sample
//   i_thresh        onset margin above the envelope
//   o_env_out       current envelope value
//   o_evt_valid     event record available
//   i_evt_ready     consumer accepts the record when valid && ready
//   o_evt_peak      largest sample seen during the attack
//   o_evt_rise      number of attack samples, including the trigger sample
//   o_evt_overflow  sticky flag: an event was dropped because the slot was full
//   o_state_out     00 IDLE, 01 ATTACK, 10 HOLD
// ---------------------------------------------------------------------------
module transient_onset_detector #(
  parameter int DW            = 8,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 5,
  parameter int HOLDOFF       = 16,
  parameter int RW            = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_sample_in,
  input  logic          i_sample_valid,
  input  logic [DW-1:0] i_thresh,
  output logic [DW-1:0] o_env_out,
  output logic          o_evt_valid,
  input  logic          i_evt_ready,
  output logic [DW-1:0] o_evt_peak,
  output logic [RW-1:0] o_evt_rise,
  output logic          o_evt_overflow,
  output logic [1:0]    o_state_out
);

  localparam int            HW        = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [DW-1:0] D_ONE     = DW'(1);
  localparam logic [DW-1:0] D_MAX     = '1;
  localparam logic [RW-1:0] R_ONE     = RW'(1);
  localparam logic [RW-1:0] R_MAX     = '1;
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ATTACK = 2'b01,
    S_HOLD   = 2'b10
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_env;
  logic [DW-1:0] r_peak;
  logic [RW-1:0] r_rise;
  logic [HW-1:0] r_hold;
  logic          r_evt_valid;
  logic [DW-1:0] r_evt_peak;
  logic [RW-1:0] r_evt_rise;
  logic          r_ovf;

  logic [DW-1:0] w_up_diff;
  logic [DW-1:0] w_dn_diff;
  logic [DW-1:0] w_up_step;
  logic [DW-1:0] w_dn_step;
  logic [DW-1:0] w_env_next;
  logic [DW:0]   w_limit_wide;
  logic [DW-1:0] w_limit;
  logic          w_trigger;
  logic          w_fall;
  logic [RW-1:0] w_rise_inc;
  logic          w_emit;
  logic [DW-1:0] w_emit_peak;
  logic [RW-1:0] w_emit_rise;
  logic          w_accept;

  // Each step is at most the distance to the sample, so the envelope never
  // passes the sample. The step is never smaller than 1.
  assign w_up_diff = i_sample_in - r_env;
  assign w_dn_diff = r_env - i_sample_in;
  assign w_up_step = ((w_up_diff >> ATTACK_SHIFT) == '0)  ? D_ONE : (w_up_diff >> ATTACK_SHIFT);
  assign w_dn_step = ((w_dn_diff >> RELEASE_SHIFT) == '0) ? D_ONE : (w_dn_diff >> RELEASE_SHIFT);

  always_comb begin
    w_env_next = r_env;
    if (i_sample_in > r_env)
      w_env_next = r_env + w_up_step;
    else if (i_sample_in < r_env)
      w_env_next = r_env - w_dn_step;
  end

  // The trigger limit uses the envelope before this sample's update. It
  // saturates so that a full-scale sample can still trigger.
  assign w_limit_wide = {1'b0, r_env} + {1'b0, i_thresh};
  assign w_limit      = w_limit_wide[DW] ? D_MAX : w_limit_wide[DW-1:0];
  assign w_trigger    = (i_sample_in >= w_limit);

  // An attack ends on the first falling sample, or when the rise count
  // saturates. A falling sample does not become part of the record.
  assign w_fall      = (i_sample_in < r_peak);
  assign w_rise_inc  = (r_rise == R_MAX) ? r_rise : r_rise + R_ONE;
  assign w_emit      = i_sample_valid && (r_state == S_ATTACK) &&
                       (w_fall || (w_rise_inc == R_MAX));
  assign w_emit_peak = w_fall ? r_peak : i_sample_in;
  assign w_emit_rise = w_fall ? r_rise : w_rise_inc;
  assign w_accept    = r_evt_valid && i_evt_ready;

  // The envelope, the FSM and the event slot are updated together.
  // A slot that is being accepted in the same cycle counts as free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_env       <= '0;
      r_peak      <= '0;
      r_rise      <= '0;
      r_hold      <= '0;
      r_evt_valid <= 1'b0;
      r_evt_peak  <= '0;
      r_evt_rise  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (i_sample_valid) begin
        r_env <= w_env_next;
        case (r_state)
          S_IDLE: begin
            if (w_trigger) begin
              r_state <= S_ATTACK;
              r_peak  <= i_sample_in;
              r_rise  <= R_ONE;
            end
          end
          S_ATTACK: begin
            if (w_emit) begin
              r_state <= (HOLDOFF == 0) ? S_IDLE : S_HOLD;
              r_hold  <= HOLD_LOAD;
            end else begin
              r_peak <= i_sample_in;
              r_rise <= w_rise_inc;
            end
          end
          S_HOLD: begin
            // The sample that empties the holdoff only returns the FSM to
            // IDLE. It cannot trigger an onset itself.
            r_hold <= r_hold - H_ONE;
            if (r_hold <= H_ONE)
              r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end

      if (w_emit) begin
        if (!r_evt_valid || w_accept) begin
          r_evt_valid <= 1'b1;
          r_evt_peak  <= w_emit_peak;
          r_evt_rise  <= w_emit_rise;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_accept) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign o_env_out      = r_env;
  assign o_evt_valid    = r_evt_valid;
  assign o_evt_peak     = r_evt_peak;
  assign o_evt_rise     = r_evt_rise;
  assign o_evt_overflow = r_ovf;
  assign o_state_out    = r_state;

endmodule

// File: tb/tb_transient_onset_detector.sv
`timescale 1ns/1ps
module tb_transient_onset_detector;

  // Shared stimulus drives both instances: the default build and a
  // narrow rise counter build used for the saturation corner
  logic       clk = 1'b0;
  logic       rst;
  logic       sampleValid;
  logic       evtReady;
  logic [7:0] sampleIn;
  logic [7:0] thresh;

  logic [7:0] envOut, evtPeak, evtRise;
  logic       evtValid, evtOverflow;
  logic [1:0] stateOut;

  logic [7:0] envOut4, evtPeak4;
  logic [3:0] evtRise4;
  logic       evtValid4, evtOverflow4;
  logic [1:0] stateOut4;

  int checks   = 0;
  int failures = 0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  transient_onset_detector dut (
    .i_clk(clk), .i_rst(rst), .i_sample_in(sampleIn), .i_sample_valid(sampleValid),
    .i_thresh(thresh), .o_env_out(envOut), .o_evt_valid(evtValid), .i_evt_ready(evtReady),
    .o_evt_peak(evtPeak), .o_evt_rise(evtRise), .o_evt_overflow(evtOverflow),
    .o_state_out(stateOut)
  );

  transient_onset_detector #(.RW(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_sample_in(sampleIn), .i_sample_valid(sampleValid),
    .i_thresh(thresh), .o_env_out(envOut4), .o_evt_valid(evtValid4), .i_evt_ready(evtReady),
    .o_evt_peak(evtPeak4), .o_evt_rise(evtRise4), .o_evt_overflow(evtOverflow4),
    .o_state_out(stateOut4)
  );

  typedef struct {
    bit rst; bit valid; int sample; int thresh; bit ready;
    bit chkEnv; int env; bit chkEvt; bit evtValid; int peak; int rise; bit ovf; int state;
  } vec_t;

  typedef struct { int peak; int rise; } rec_t;

  vec_t vecs[$];

  // Reference model: envelope as an integer, mode numbered as state_out,
  // and the event slot as a queue holding at most one record
  int   mEnv, mMode, mPeak, mRise, mHold;
  bit   mOvf;
  rec_t mSlot[$];

  function automatic vec_t mkVec(bit r, bit v, int s, int t, bit rd, bit ce, int e,
                                 bit ck, bit ev, int p, int ri, bit o, int st);
    vec_t x;
    x.rst = r; x.valid = v; x.sample = s; x.thresh = t; x.ready = rd;
    x.chkEnv = ce; x.env = e; x.chkEvt = ck; x.evtValid = ev; x.peak = p;
    x.rise = ri; x.ovf = o; x.state = st;
    return x;
  endfunction

  // Drive one cycle of inputs, then let the edge pass before outputs are read
  task automatic applyStimulus(input bit r, input bit v, input int s, input int t, input bit rd);
    rst = r; sampleValid = v; sampleIn = 8'(s); thresh = 8'(t); evtReady = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One sample of the behavioural model, applied with the current inputs
  task automatic modelStep(input bit r, input bit v, input int s, input int t,
                           input bit rd, input int riseMax);
    bit   emit;
    bit   accept;
    rec_t rec;
    int   limit;
    if (r) begin
      mEnv = 0; mMode = 0; mPeak = 0; mRise = 0; mHold = 0; mOvf = 0;
      mSlot.delete();
      return;
    end
    accept = (mSlot.size() != 0) && rd;
    emit = 0;
    if (v) begin
      limit = mEnv + t;
      if (limit > 255) limit = 255;
      if (mMode == 0) begin
        if (s >= limit) begin mMode = 1; mPeak = s; mRise = 1; end
      end else if (mMode == 1) begin
        if (s < mPeak) begin
          emit = 1; rec.peak = mPeak; rec.rise = mRise;
        end else begin
          mPeak = s;
          mRise = (mRise + 1 > riseMax) ? riseMax : mRise + 1;
          if (mRise == riseMax) begin emit = 1; rec.peak = mPeak; rec.rise = mRise; end
        end
        if (emit) begin mMode = 2; mHold = 16; end
      end else begin
        mHold--;
        if (mHold == 0) mMode = 0;
      end
      if (s > mEnv) mEnv += ((s - mEnv) >> 2) < 1 ? 1 : ((s - mEnv) >> 2);
      else if (s < mEnv) mEnv -= ((mEnv - s) >> 5) < 1 ? 1 : ((mEnv - s) >> 5);
    end
    if (accept) void'(mSlot.pop_front());
    if (emit) begin
      if (mSlot.size() == 0) mSlot.push_back(rec);
      else mOvf = 1;
    end
  endtask

  // Directed table first, then the multi-cycle corner sequences, then random
  initial begin
    int settleEnv[16] = '{7, 13, 17, 20, 22, 24, 25, 26, 27, 28, 29, 30, 31, 31, 31, 31};
    bit r, v, rd;
    int s, t;

    rst = 1'b1; sampleValid = 1'b0; sampleIn = '0; thresh = '0; evtReady = 1'b0;

    for (int i = 0; i < 3; i++)
      vecs.push_back(mkVec(1, 1, 8'hFF - i, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mkVec(0, 1, 8'h1F, 8'h40, 0, 1, settleEnv[i], 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'hBF, 8'h40, 0, 1, 71, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(0, 1, 8'h1F, 8'h40, 0, 1, 70, 1, 1, 8'hBF, 1, 0, 2));
    vecs.push_back(mkVec(0, 0, 8'h00, 8'h40, 1, 1, 70, 0, 0, 0, 0, 0, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].sample, vecs[i].thresh, vecs[i].ready);
      if (vecs[i].chkEnv) checkOutput($sformatf("vec%0d_env", i), envOut, vecs[i].env);
      checkOutput($sformatf("vec%0d_state", i), stateOut, vecs[i].state);
      checkOutput($sformatf("vec%0d_evtValid", i), evtValid, vecs[i].evtValid);
      checkOutput($sformatf("vec%0d_ovf", i), evtOverflow, vecs[i].ovf);
      if (vecs[i].chkEvt) begin
        checkOutput($sformatf("vec%0d_peak", i), evtPeak, vecs[i].peak);
        checkOutput($sformatf("vec%0d_rise", i), evtRise, vecs[i].rise);
      end
    end

    // Holdoff: full-scale samples during HOLD must not retrigger
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(0, 1, 8'hFF, 8'h40, 0);
      checkOutput($sformatf("holdoff%0d_state", k), stateOut, (k <= 15) ? 2 : (k == 16 ? 0 : 1));
      checkOutput($sformatf("holdoff%0d_evtValid", k), evtValid, 0);
    end

    // Backpressure: the first record stays put and the second one is lost
    applyStimulus(0, 1, 8'h00, 8'h40, 0);
    checkOutput("bp_first_state", stateOut, 2);
    checkOutput("bp_first_valid", evtValid, 1);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 1, 8'h00, 8'h10, 0);
      checkOutput($sformatf("bp_hold%0d_valid", k), evtValid, 1);
      checkOutput($sformatf("bp_hold%0d_peak", k), evtPeak, 8'hFF);
      checkOutput($sformatf("bp_hold%0d_rise", k), evtRise, 1);
    end
    checkOutput("bp_idle_state", stateOut, 0);
    applyStimulus(0, 1, 8'hFF, 8'h10, 0);
    checkOutput("bp_second_attack", stateOut, 1);
    applyStimulus(0, 1, 8'hFF, 8'h10, 0);
    applyStimulus(0, 1, 8'h00, 8'h10, 0);
    checkOutput("bp_second_state", stateOut, 2);
    checkOutput("bp_overflow", evtOverflow, 1);
    checkOutput("bp_kept_peak", evtPeak, 8'hFF);
    checkOutput("bp_kept_rise", evtRise, 1);
    checkOutput("bp_kept_valid", evtValid, 1);
    applyStimulus(0, 0, 8'h00, 8'h10, 1);
    checkOutput("bp_accept_valid", evtValid, 0);
    checkOutput("bp_ovf_sticky", evtOverflow, 1);

    // Slow ramp: the narrow instance saturates its rise count at 15
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("ramp_reset_ovf", evtOverflow, 0);
    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 1, k, 1, 0);
      if (k == 14) begin
        checkOutput("ramp4_pre_state", stateOut4, 1);
        checkOutput("ramp4_pre_valid", evtValid4, 0);
      end
      if (k == 15) begin
        checkOutput("ramp4_state", stateOut4, 2);
        checkOutput("ramp4_valid", evtValid4, 1);
        checkOutput("ramp4_peak", evtPeak4, 15);
        checkOutput("ramp4_rise", evtRise4, 15);
        checkOutput("ramp4_ovf", evtOverflow4, 0);
      end
      if (k == 254) begin
        checkOutput("ramp8_pre_state", stateOut, 1);
        checkOutput("ramp8_pre_valid", evtValid, 0);
      end
      if (k == 255) begin
        checkOutput("ramp8_state", stateOut, 2);
        checkOutput("ramp8_valid", evtValid, 1);
        checkOutput("ramp8_peak", evtPeak, 255);
        checkOutput("ramp8_rise", evtRise, 255);
      end
    end

    // Random traffic against the behavioural model
    modelStep(1, 0, 0, 0, 0, 255);
    applyStimulus(1, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 99) < 60);
      s  = $urandom_range(0, 255);
      t  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 80);
      rd = ($urandom_range(0, 99) < 30);
      modelStep(r, v, s, t, rd, 255);
      applyStimulus(r, v, s, t, rd);
      checkOutput($sformatf("rnd%0d_env", n), envOut, mEnv);
      checkOutput($sformatf("rnd%0d_state", n), stateOut, mMode);
      checkOutput($sformatf("rnd%0d_valid", n), evtValid, (mSlot.size() != 0) ? 1 : 0);
      checkOutput($sformatf("rnd%0d_ovf", n), evtOverflow, mOvf);
      if (mSlot.size() != 0) begin
        checkOutput($sformatf("rnd%0d_peak", n), evtPeak, mSlot[0].peak);
        checkOutput($sformatf("rnd%0d_rise", n), evtRise, mSlot[0].rise);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
